ram_fifo_ctrl: RTL and testbench

//  Synchronous FIFO built around one ram_2ports instance. Owns write/read pointers, occupancy count and status flags,
//  and sequences the RAM write port (push) and read address (pop). First-word-fall-through: head word visible on rd_data

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/ram_2ports.sv | 26 ++
 rtl/ram_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH      = 3;
  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_ALMOST_EMPTY_TH = 1;
  localparam int DEF_CNT_WIDTH       = DEF_ADDR_WIDTH + 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Occupancy must represent 0..DEPTH inclusive, hence one bit over the address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int af_th_default(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/ram_2ports.sv
// Simple dual-port storage: synchronous write, asynchronous (combinational) read.
module ram_2ports
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  write_en_i,
  input  logic [AW-1:0]         w_addr_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [AW-1:0]         r_addr_i,
  output logic [DATA_WIDTH-1:0] r_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset; only the controller pointers are.
  always_ff @(posedge clk_i) begin
    if (write_en_i) mem_q[w_addr_i] <= w_data_i;
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around ram_2ports.
// Optional macro FIFO_ERR_FLAGS_EN adds registered overflow/underflow outputs.
module ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ALMOST_FULL_TH  = af_th_default(ADDR_WIDTH),
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
`else
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_TH);

  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af_th
    $error("ram_fifo_ctrl: ALMOST_FULL_TH must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae_th
    $error("ram_fifo_ctrl: ALMOST_EMPTY_TH must be in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  // Handshake: wr_en/wr_data is a push offer, accepted when not full or when a pop
  // frees the head slot in the same cycle. rd_en acknowledges the word currently
  // on rd_data and is honoured only when the FIFO is not empty.
  assign push_ok = wr_en & (~full | rd_en);
  assign pop_ok  = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flags decode straight from the count register so they never glitch mid-cycle.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_TH);
  assign almost_empty = (count_q <= AE_TH);
  assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en & ~push_ok;
      underflow_q <= rd_en & empty;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  ram_2ports #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (ADDR_WIDTH)
  ) u_ram (
    .clk_i      (clk),
    .write_en_i (push_ok),
    .w_addr_i   (wr_ptr_q),
    .w_data_i   (wr_data),
    .r_addr_i   (rd_ptr_q),
    .r_data_o   (rd_data)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed, table-driven bench for ram_fifo_ctrl at default parameters (DEPTH=8).
module tb_ram_fifo_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         full, empty, almost_full, almost_empty;
  logic [3:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic         overflow, underflow;
`endif

  ram_fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
`else
    .count        (count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] wd;
    logic         chk_d;
    logic [W-1:0] exp_d;
    logic [3:0]   exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  function automatic void add(input logic wr, input logic rd, input logic [W-1:0] wd,
                              input logic chk_d, input logic [W-1:0] exp_d,
                              input logic [3:0] exp_cnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd;
    v.chk_d = chk_d; v.exp_d = exp_d; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status outputs compared against the flag definitions applied to the expected count.
  task automatic chk_status(input string tag, input logic [3:0] exp_cnt);
    chk({tag, " count"},        32'(count),        32'(exp_cnt));
    chk({tag, " empty"},        32'(empty),        32'(exp_cnt == 4'd0));
    chk({tag, " full"},         32'(full),         32'(exp_cnt == 4'd8));
    chk({tag, " almost_full"},  32'(almost_full),  32'(exp_cnt >= 4'd7));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(exp_cnt <= 4'd1));
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [W-1:0] wd);
    @(negedge clk);
    wr_en = wr; rd_en = rd; wr_data = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #6 reset = 1'b0;

    // 1: idle after reset, pop on empty ignored
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);
    add(0, 1, 8'h00, 0, 8'h00, 4'd0);
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);
    // 2: fill to full, ninth push dropped
    for (int i = 0; i < 8; i++) add(1, 0, 8'(8'h11 + i), i > 0, 8'h11, 4'(i));
    add(1, 0, 8'h99, 1, 8'h11, 4'd8);
    add(0, 0, 8'h00, 1, 8'h11, 4'd8);
    // 3: drain in order, then refill after the pointers have wrapped
    for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 1, 8'(8'h11 + i), 4'(8 - i));
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);
    add(1, 0, 8'hA0, 0, 8'h00, 4'd0);
    add(0, 1, 8'h00, 1, 8'hA0, 4'd1);
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);
    // 4: push+pop while full
    for (int i = 0; i < 8; i++) add(1, 0, 8'(8'h11 + i), i > 0, 8'h11, 4'(i));
    add(1, 1, 8'h55, 1, 8'h11, 4'd8);
    for (int i = 0; i < 7; i++) add(0, 1, 8'h00, 1, 8'(8'h12 + i), 4'(8 - i));
    add(0, 1, 8'h00, 1, 8'h55, 4'd1);
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);
    // 5: steady-state streaming at count 3
    for (int i = 0; i < 3; i++)  add(1, 0, 8'(8'h21 + i), i > 0, 8'h21, 4'(i));
    for (int i = 0; i < 10; i++) add(1, 1, 8'(8'h24 + i), 1, 8'(8'h21 + i), 4'd3);
    for (int i = 0; i < 3; i++)  add(0, 1, 8'h00, 1, 8'(8'h2B + i), 4'(3 - i));
    add(0, 0, 8'h00, 0, 8'h00, 4'd0);

    // Check after inputs settle, before the rising edge that consumes them.
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].wr, vecs[k].rd, vecs[k].wd);
      #1;
      chk_status($sformatf("vec%0d", k), vecs[k].exp_cnt);
      if (vecs[k].chk_d) chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vecs[k].exp_d));
    end

    // 6: async reset between edges with five words held
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h31 + i));
    drive(0, 0, 8'h00);
    #1 chk_status("pre_reset", 4'd5);
    chk("pre_reset rd_data", 32'(rd_data), 32'h31);
    #1 reset = 1'b1;
    #1 chk_status("async_reset", 4'd0);
    #1 reset = 1'b0;
    drive(1, 0, 8'h77);
    drive(0, 0, 8'h00);
    #1 chk_status("post_reset", 4'd1);
    chk("post_reset rd_data", 32'(rd_data), 32'h77);

`ifdef FIFO_ERR_FLAGS_EN
    do_reset();
    drive(0, 1, 8'h00);
    drive(0, 0, 8'h00);
    #1 chk("underflow set", 32'(underflow), 32'h1);
    drive(0, 0, 8'h00);
    #1 chk("underflow clear", 32'(underflow), 32'h0);
    for (int i = 0; i < 8; i++) drive(1, 0, 8'(8'h41 + i));
    drive(1, 0, 8'hEE);
    drive(0, 0, 8'h00);
    #1 chk("overflow set", 32'(overflow), 32'h1);
    chk_status("overflow", 4'd8);
    drive(1, 1, 8'hEF);
    drive(0, 0, 8'h00);
    #1 chk("overflow clear on push+pop", 32'(overflow), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
